// File: rtl/op_cmd_sequencer_pkg.sv
// Shared constants for the command sequencer: opcodes, status words, register map, FSM states.
// Opcode values come from the MULTIPLICATION_OPERATION / CONVOLUTION_OPERATION macros when predefined.
`ifndef MULTIPLICATION_OPERATION
`define MULTIPLICATION_OPERATION 32'h0000_0001
`endif
`ifndef CONVOLUTION_OPERATION
`define CONVOLUTION_OPERATION 32'h0000_0002
`endif

package op_cmd_sequencer_pkg;

  localparam logic [31:0] OP_MULT      = `MULTIPLICATION_OPERATION;
  localparam logic [31:0] OP_CONV      = `CONVOLUTION_OPERATION;
  localparam logic [31:0] STATUS_START = 32'hFFFF_FFFF;
  localparam logic [31:0] STATUS_IDLE  = 32'h0000_0000;

  localparam logic [3:0] ADDR_CMD     = 4'h0;
  localparam logic [3:0] ADDR_STAT    = 4'h4;
  localparam logic [3:0] ADDR_DONECNT = 4'h8;
  localparam logic [3:0] ADDR_CTRL    = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  function automatic logic is_valid_op(input logic [31:0] v);
    return (v == OP_MULT) || (v == OP_CONV);
  endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous command FIFO; full/empty derived from pointers carrying one extra wrap bit.
// Flush empties the FIFO and discards a same-cycle push; the head is still readable during a flush.
module op_cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign pop_ok  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/op_cmd_sequencer.sv
// Command front end: bus register decode, command FIFO, start/finish handshake FSM, DONECNT.
// Optional completion interrupt built only when OPSEQ_IRQ_EN is defined.
module op_cmd_sequencer
  import op_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        finished,
  output logic [31:0] operation,
  output logic [31:0] status,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  seq_state_t  state, state_nx;
  logic        wr_cmd, wr_ctrl, flush, clr;
  logic        push_req, rej_set;
  logic        pop, start, done;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [31:0] fifo_head;
  logic [CNT_W-1:0] done_cnt;
  logic        rej;
  logic        irq_pend;
  logic [31:0] rd_mux;

  assign wr_cmd   = bus_we && (bus_addr == ADDR_CMD);
  assign wr_ctrl  = bus_we && (bus_addr == ADDR_CTRL);
  assign flush    = wr_ctrl && bus_wdata[0];
  assign clr      = wr_ctrl && bus_wdata[1];
  assign push_req = wr_cmd && is_valid_op(bus_wdata);
  assign rej_set  = wr_cmd && (!is_valid_op(bus_wdata) || (fifo_full && !pop));

  op_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .wdata (bus_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ST_ARM;
        end
      end
      ST_ARM: begin
        start    = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (finished) begin
          done     = 1'b1;
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!finished) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs: operation settles in ARM, a cycle ahead of the start request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operation <= '0;
      status    <= STATUS_IDLE;
    end else begin
      if (pop) operation <= fifo_head;
      if (start)     status <= STATUS_START;
      else if (done) status <= STATUS_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_cnt <= '0;
      rej      <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1'b1;
      if (rej_set)  rej <= 1'b1;
      else if (clr) rej <= 1'b0;
    end
  end

`ifdef OPSEQ_IRQ_EN
  // A completion beats a simultaneous clear so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     irq_pend <= 1'b0;
    else if (done) irq_pend <= 1'b1;
    else if (clr)  irq_pend <= 1'b0;
  end
`else
  assign irq_pend = 1'b0;
`endif

  assign irq = irq_pend;

  always_comb begin
    rd_mux = 32'h0;
    case (bus_addr)
      ADDR_STAT:    rd_mux = {19'b0, irq_pend, rej, (state != ST_IDLE), fifo_empty, fifo_full,
                              8'(fifo_count)};
      ADDR_DONECNT: rd_mux = 32'(done_cnt);
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_we || bus_re;
      bus_rdata <= bus_re ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_op_cmd_sequencer.sv
// Self-checking bench for op_cmd_sequencer with a queue-based reference model of the command flow.
`timescale 1ns/1ps
module tb_op_cmd_sequencer;

  localparam logic [31:0] MULT  = 32'h0000_0001;
  localparam logic [31:0] CONV  = 32'h0000_0002;
  localparam logic [31:0] START = 32'hFFFF_FFFF;
  localparam int DEPTH = 4;
`ifdef OPSEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, reset, bus_we, bus_re, finished, bus_ack, irq;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata, operation, status;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int done_m = 0;
  bit rej_m = 0, irq_m = 0;
  int rise_cnt = 0;
  logic [31:0] prev_op = '0, rise_prev_op = '0, prev_status = '0;

  op_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .finished(finished),
    .operation(operation), .status(status), .irq(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed no end expected end of test");
    $fatal(1, "timeout");
  end

  // Records each start-request window and the opcode seen the cycle before it opened.
  always @(negedge clk) begin
    if (status === START && prev_status !== START) begin
      rise_cnt++;
      rise_prev_op = prev_op;
    end
    prev_status = status;
    prev_op = operation;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_we = 1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_we = 0;
    check("wr_ack", {31'b0, bus_ack}, 32'h1);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_re = 1; bus_addr = a;
    @(negedge clk);
    bus_re = 0;
    check("rd_ack", {31'b0, bus_ack}, 32'h1);
    d = bus_rdata;
  endtask

  function automatic logic [31:0] stat_exp(input int cnt, input bit busy);
    return {19'b0, irq_m & IRQ_EN, rej_m, busy, cnt == 0, cnt == DEPTH, 8'(cnt)};
  endfunction

  function automatic logic [31:0] rand_invalid();
    logic [31:0] v;
    v = $urandom;
    while (v == MULT || v == CONV) v = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rand_op();
    return ($urandom_range(0, 1) == 1) ? MULT : CONV;
  endfunction

  task automatic push_op(input logic [31:0] op);
    bus_write(4'h0, op);
    exp_q.push_back(op);
  endtask

  task automatic check_stat(input string tag, input int cnt, input bit busy);
    logic [31:0] d;
    bus_read(4'h4, d);
    check(tag, d, stat_exp(cnt, busy));
  endtask

  task automatic check_donecnt(input string tag);
    logic [31:0] d;
    bus_read(4'h8, d);
    check(tag, d, 32'(done_m));
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (status === START) break;
    end
    check({tag, "_start_seen"}, {31'b0, status === START}, 32'h1);
    #1;
  endtask

  // Acts as the control unit for one operation and checks the opcode against the model queue.
  task automatic serve_one(input string tag);
    logic [31:0] e;
    wait_start(tag);
    e = 32'hxxxx_xxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_op"}, operation, e);
    check({tag, "_op_prearm"}, rise_prev_op, e);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({tag, "_hold"}, status, START);
    finished = 1;
    @(negedge clk);
    done_m++;
    irq_m = 1;
    check({tag, "_fin_status"}, status, 32'h0);
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, IRQ_EN});
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check({tag, "_drain_status"}, status, 32'h0);
    finished = 0;
  endtask

  initial begin
    logic [31:0] d;
    int k, r0;
    reset = 1; bus_we = 0; bus_re = 0; bus_addr = 0; bus_wdata = 0; finished = 0;
    #1;
    check("rst_operation", operation, 32'h0);
    check("rst_status", status, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_ack_irq", {30'b0, bus_ack, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    check_stat("rst_stat", 0, 0);
    check_donecnt("rst_donecnt");

    // Single operation
    push_op(MULT);
    serve_one("single");
    repeat (2) @(negedge clk);
    check_donecnt("single_donecnt");
    check_stat("single_stat_idle", 0, 0);

    // Back-to-back MULT, CONV, MULT
    r0 = rise_cnt;
    push_op(MULT); push_op(CONV); push_op(MULT);
    for (int i = 0; i < 3; i++) serve_one("b2b");
    repeat (3) @(negedge clk);
    check("b2b_windows", 32'(rise_cnt - r0), 32'd3);
    check_donecnt("b2b_donecnt");

    // Overflow and invalid opcode
    bus_write(4'hC, 32'h2); rej_m = 0; irq_m = 0;
    for (int i = 0; i < 5; i++) push_op(rand_op());
    bus_write(4'h0, 32'hDEAD_BEEF); rej_m = 1;
    check_stat("ovf_stat", 4, 1);
    bus_write(4'h0, MULT);
    check_stat("ovf_full_push", 4, 1);
    bus_write(4'hC, 32'h2); rej_m = 0; irq_m = 0;
    check_stat("ovf_rej_clr", 4, 1);
    for (int i = 0; i < 5; i++) serve_one("ovf");
    repeat (2) @(negedge clk);
    check_donecnt("ovf_donecnt");

    // Read-only writes ignored, CMD/CTRL read as 0
    bus_write(4'h8, 32'h0000_1234);
    bus_write(4'h4, 32'hFFFF_FFFF);
    check_donecnt("ro_donecnt");
    check_stat("ro_stat", 0, 0);
    bus_read(4'h0, d); check("cmd_read", d, 32'h0);
    bus_read(4'hC, d); check("ctrl_read", d, 32'h0);

    // Flush while an op is running
    r0 = rise_cnt;
    push_op(CONV);
    wait_start("flush_pre");
    push_op(MULT); push_op(CONV); push_op(MULT);
    check_stat("flush_queued", 3, 1);
    bus_write(4'hC, 32'h1);
    void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
    check_stat("flush_stat", 0, 1);
    serve_one("flush");
    repeat (12) @(negedge clk);
    check("flush_windows", 32'(rise_cnt - r0), 32'd1);
    check("flush_idle_status", status, 32'h0);
    check_donecnt("flush_donecnt");

    // Randomised rounds against the model
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        push_op(rand_op());
        if ($urandom_range(0, 2) == 0) begin
          bus_write(4'h0, rand_invalid());
          rej_m = 1;
        end
      end
      check_stat("rnd_stat", k - 1, 1);
      for (int j = 0; j < k; j++) serve_one("rnd");
      repeat (2) @(negedge clk);
      check_donecnt("rnd_donecnt");
      if ($urandom_range(0, 1) == 1) begin
        bus_write(4'hC, 32'h2); rej_m = 0; irq_m = 0;
        check_stat("rnd_clr_stat", 0, 0);
      end
    end

    // Completion and interrupt clear in the same cycle
    bus_write(4'hC, 32'h2); rej_m = 0; irq_m = 0;
    check("irq_cleared", {31'b0, irq}, 32'h0);
    push_op(CONV);
    wait_start("irq_same");
    check("irq_same_op", operation, exp_q.pop_front());
    finished = 1; bus_we = 1; bus_addr = 4'hC; bus_wdata = 32'h2;
    @(negedge clk);
    bus_we = 0;
    done_m++; irq_m = 1;
    check("irq_same_status", status, 32'h0);
    check("irq_same_keep", {31'b0, irq}, {31'b0, IRQ_EN});
    finished = 0;
    check_stat("irq_same_stat", 0, 0);
    bus_write(4'hC, 32'h2); irq_m = 0;
    check("irq_later_clr", {31'b0, irq}, 32'h0);
    check_donecnt("irq_donecnt");

    // Asynchronous reset mid-RUN
    push_op(MULT); push_op(CONV);
    wait_start("rst_mid");
    #2;
    reset = 1;
    #1;
    check("rstmid_status", status, 32'h0);
    check("rstmid_operation", operation, 32'h0);
    check("rstmid_irq", {31'b0, irq}, 32'h0);
    exp_q.delete(); done_m = 0; rej_m = 0; irq_m = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    check_stat("rstmid_stat", 0, 0);
    check_donecnt("rstmid_donecnt");
    push_op(MULT);
    serve_one("post_rst");
    repeat (2) @(negedge clk);
    check_donecnt("post_rst_donecnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
